// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit and its program store.
// These are the opcode values, the fetch FSM encoding and the default widths shared with simple_cpu.
package instr_fetch_unit_pkg;

    localparam int INSTR_WIDTH_DEF = 20;
    localparam int ADDR_BITS_DEF   = 5;
    localparam int CNT_WIDTH_DEF   = 8;
    localparam int OPCODE_BITS     = 4;

    localparam logic [OPCODE_BITS-1:0] OP_NOP  = 4'h0;
    localparam logic [OPCODE_BITS-1:0] OP_LOAD = 4'h1;
    localparam logic [OPCODE_BITS-1:0] OP_ADD  = 4'h2;
    localparam logic [OPCODE_BITS-1:0] OP_SUB  = 4'h3;
    localparam logic [OPCODE_BITS-1:0] OP_HALT = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_ISSUE = 2'd2,
        ST_HALT  = 2'd3
    } fetch_state_t;

    // True when the opcode terminates fetch.
    function automatic logic is_halt(input logic [OPCODE_BITS-1:0] opcode,
                                     input logic [OPCODE_BITS-1:0] halt_opcode);
        return opcode == halt_opcode;
    endfunction

endpackage

// File: rtl/instr_fetch_unit_rom.sv
// Program store: a 2**ADDR_BITS x DATA_WIDTH array.
// It has a synchronous write and a registered read.
// The array itself is never reset, so a loaded program survives rst.
// Only the read register clears on reset, because it feeds the instruction output directly.
module instr_fetch_unit_rom
    import instr_fetch_unit_pkg::*;
#(
    parameter int DATA_WIDTH = INSTR_WIDTH_DEF,
    parameter int ADDR_BITS  = ADDR_BITS_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_BITS-1:0]  wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_BITS-1:0]  rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [0:(2**ADDR_BITS)-1];
    logic [DATA_WIDTH-1:0] rd_data_reg;

    // Array write port; no reset so the store maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read.
    // The value is held between reads so the consumer sees a stable word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_reg <= '0;
        end else if (rd_en) begin
            rd_data_reg <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_reg;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues words from the program store to the CPU with a valid/ready handshake.
// The PC steps sequentially or takes a branch target on each handshake.
// Fetch stops once a HALT word has been accepted.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int                     INSTR_WIDTH = INSTR_WIDTH_DEF,
    parameter int                     ADDR_BITS   = ADDR_BITS_DEF,
    parameter logic [OPCODE_BITS-1:0] HALT_OPCODE = OP_HALT,
    parameter int                     CNT_WIDTH   = CNT_WIDTH_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   prog_wen,
    input  logic [ADDR_BITS-1:0]   prog_addr,
    input  logic [INSTR_WIDTH-1:0] prog_data,
    input  logic                   start,
    input  logic                   instr_ready,
    input  logic                   branch_valid,
    input  logic [ADDR_BITS-1:0]   branch_target,
    output logic [INSTR_WIDTH-1:0] instruction,
    output logic                   instr_valid,
    output logic [ADDR_BITS-1:0]   pc,
    output logic                   halted,
    output logic [CNT_WIDTH-1:0]   issued_count
);

    fetch_state_t           state_reg;
    logic [ADDR_BITS-1:0]   pc_reg;
    logic                   valid_reg;
    logic                   halted_reg;
    logic [CNT_WIDTH-1:0]   count_reg;

    logic                   loadable;
    logic                   store_wen;
    logic                   store_ren;
    logic                   handshake;
    logic [OPCODE_BITS-1:0] opcode;

    // The loader port and start are only honoured while fetch is stopped.
    assign loadable  = (state_reg == ST_IDLE) || (state_reg == ST_HALT);
    assign store_wen = prog_wen & loadable;
    assign store_ren = (state_reg == ST_FETCH);
    assign handshake = (state_reg == ST_ISSUE) & valid_reg & instr_ready;
    assign opcode    = instruction[INSTR_WIDTH-1 -: OPCODE_BITS];

    // The store's read register doubles as the instruction output register.
    // It is only loaded in FETCH, so the word is held steady throughout ISSUE.
    instr_fetch_unit_rom #(
        .DATA_WIDTH (INSTR_WIDTH),
        .ADDR_BITS  (ADDR_BITS)
    ) u_rom (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (store_wen),
        .wr_addr (prog_addr),
        .wr_data (prog_data),
        .rd_en   (store_ren),
        .rd_addr (pc_reg),
        .rd_data (instruction)
    );

    // Fetch FSM with registered PC, valid, halted and issue counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= ST_IDLE;
            pc_reg     <= '0;
            valid_reg  <= 1'b0;
            halted_reg <= 1'b0;
            count_reg  <= '0;
        end else begin
            case (state_reg)
                ST_IDLE, ST_HALT: begin
                    if (start) begin
                        halted_reg <= 1'b0;
                        pc_reg     <= '0;
                        count_reg  <= '0;
                        state_reg  <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    valid_reg <= 1'b1;
                    state_reg <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    if (handshake) begin
                        count_reg <= count_reg + CNT_WIDTH'(1);
                        valid_reg <= 1'b0;
                        if (is_halt(opcode, HALT_OPCODE)) begin
                            // A branch presented alongside HALT is deliberately dropped.
                            halted_reg <= 1'b1;
                            state_reg  <= ST_HALT;
                        end else begin
                            pc_reg    <= branch_valid ? branch_target : pc_reg + ADDR_BITS'(1);
                            state_reg <= ST_FETCH;
                        end
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign instr_valid  = valid_reg;
    assign pc           = pc_reg;
    assign halted       = halted_reg;
    assign issued_count = count_reg;

endmodule
